// File: rtl/vga_pkg.sv
// Shared timing defaults (640x480@60), FSM state type and RGB565 colour-bar constants
// for the VGA FIFO reader.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic {S_WAIT, S_RUN} state_t;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = RGB_WHITE;
      3'd1:    bar_color = RGB_YELLOW;
      3'd2:    bar_color = RGB_CYAN;
      3'd3:    bar_color = RGB_GREEN;
      3'd4:    bar_color = RGB_MAGENTA;
      3'd5:    bar_color = RGB_RED;
      3'd6:    bar_color = RGB_BLUE;
      default: bar_color = RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_fifo_reader_if.sv
// Pixel-FIFO read port plus video pin bundle; master = the FIFO reader.
interface vga_fifo_reader_if #(
  parameter int unsigned B = 16
);
  logic         fifo_empty;
  logic [B-1:0] fifo_rd_data;
  logic         fifo_rd;
  logic         hsync_n;
  logic         vsync_n;
  logic         de;
  logic [B-1:0] pixel;

  modport master (
    input  fifo_empty, fifo_rd_data,
    output fifo_rd, hsync_n, vsync_n, de, pixel
  );

  modport slave (
    output fifo_empty, fifo_rd_data,
    input  fifo_rd, hsync_n, vsync_n, de, pixel
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster h/v counters with stage-0 active/sync decode and frame-boundary flags.
// VGA_TEST_PATTERN_EN adds the colour-bar index output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       active,
  output logic       hs,
  output logic       vs,
  output logic       frame_origin,
`ifdef VGA_TEST_PATTERN_EN
  output logic [2:0] bar_idx,
`endif
  output logic       frame_end
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  assign active       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs           = (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign vs           = (v_cnt >= V_SS) && (v_cnt < V_SE);
  assign frame_origin = (h_cnt == '0) && (v_cnt == '0);
  assign frame_end    = (h_cnt == H_LAST) && (v_cnt == V_LAST);

`ifdef VGA_TEST_PATTERN_EN
  assign bar_idx = 3'(h_cnt / HW'(H_ACTIVE / 8));
`endif

endmodule

// File: rtl/vga_fifo_reader.sv
// VGA raster consumer of the pixel FIFO: read control, 2-stage output pipeline,
// WAIT/RUN frame FSM and sticky underflow. VGA_TEST_PATTERN_EN adds test_mode colour bars.
module vga_fifo_reader
  import vga_pkg::*;
#(
  parameter int unsigned B        = 16,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter logic [B-1:0] FILL    = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clr_underflow,
`ifdef VGA_TEST_PATTERN_EN
  input  logic test_mode,
`endif
  output logic frame_start,
  output logic underflow,
  vga_fifo_reader_if.master bus
);
  state_t       state, state_nxt;
  logic         active, hs, vs, frame_origin, frame_end;
  logic         rd, uf_hit, tm;
  logic         active_s1, hs_s1, vs_s1, fetched_s1;
  logic [B-1:0] pixel_nxt;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_idx, bar_s1;
  logic       tm_s1;
  assign tm = test_mode;
`else
  assign tm = 1'b0;
`endif

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk),
    .rst_n(rst_n),
    .active(active),
    .hs(hs),
    .vs(vs),
    .frame_origin(frame_origin),
`ifdef VGA_TEST_PATTERN_EN
    .bar_idx(bar_idx),
`endif
    .frame_end(frame_end)
  );

  // The decision is taken on the last raster position so the new state is
  // already in effect while the counters sit at (0,0); no frame is truncated.
  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    uf_hit    = 1'b0;
    if (state == S_RUN && active && !tm) begin
      rd     = !bus.fifo_empty;
      uf_hit = bus.fifo_empty;
    end
    if (frame_end) begin
      case (state)
        S_WAIT:  if (enable && !bus.fifo_empty) state_nxt = S_RUN;
        S_RUN:   if (!enable) state_nxt = S_WAIT;
        default: state_nxt = S_WAIT;
      endcase
    end
  end

  assign bus.fifo_rd = rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= state_nxt;
  end

  always_comb begin
    pixel_nxt = fetched_s1 ? bus.fifo_rd_data : FILL;
`ifdef VGA_TEST_PATTERN_EN
    if (tm_s1 && active_s1) pixel_nxt = B'(bar_color(bar_s1));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_s1   <= 1'b0;
      hs_s1       <= 1'b0;
      vs_s1       <= 1'b0;
      fetched_s1  <= 1'b0;
      frame_start <= 1'b0;
      bus.de      <= 1'b0;
      bus.hsync_n <= 1'b1;
      bus.vsync_n <= 1'b1;
      bus.pixel   <= FILL;
      underflow   <= 1'b0;
    end else begin
      active_s1   <= active;
      hs_s1       <= hs;
      vs_s1       <= vs;
      fetched_s1  <= rd;
      frame_start <= frame_origin;
      bus.de      <= active_s1;
      bus.hsync_n <= !hs_s1;
      bus.vsync_n <= !vs_s1;
      bus.pixel   <= pixel_nxt;
      if (uf_hit)             underflow <= 1'b1;
      else if (clr_underflow) underflow <= 1'b0;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tm_s1  <= 1'b0;
      bar_s1 <= '0;
    end else begin
      tm_s1  <= tm;
      bar_s1 <= bar_idx;
    end
  end
`endif

endmodule

// File: tb/tb_vga_fifo_reader.sv
// Directed bench for vga_fifo_reader on a 14x7 raster (8x4 visible) with a queue-based FIFO model.
module tb_vga_fifo_reader;
  localparam int HT = 14;
  localparam int FR = 98;
  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic clr_underflow = 1'b0;
  logic frame_start, underflow;
`ifdef VGA_TEST_PATTERN_EN
  logic test_mode = 1'b0;
`endif

  vga_fifo_reader_if #(.B(16)) bus();

  vga_fifo_reader #(
    .B(16), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .FILL(16'h0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .clr_underflow(clr_underflow),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .frame_start(frame_start),
    .underflow(underflow),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n = 0;
  int checks = 0, passes = 0, fails = 0;
  int run_f0 = -1, avail0 = 0, run_f1 = -1, avail1 = 0;
  int uf_set_n = BIG, uf_clr_n = BIG, tm_n0 = BIG;
  logic [15:0] fifo_q[$];
  logic [15:0] bars[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                           16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  function automatic bit act(input int p);
    return ((p % HT) < 8) && ((p / HT) < 4);
  endfunction
  function automatic int widx(input int p);
    return (p / HT) * 8 + (p % HT) + 1;
  endfunction
  function automatic int avail(input int f);
    if (f == run_f0) return avail0;
    if (f == run_f1) return avail1;
    return 0;
  endfunction
  function automatic logic [31:0] exp_pix(input int q);
    int qp;
    qp = q % FR;
    if (q >= tm_n0 && act(qp)) return 32'(bars[qp % HT]);
    if (act(qp) && widx(qp) <= avail(q / FR)) return 32'(widx(qp));
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s n=%0d got %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic check_cycle();
    int p, q, qp, hq, vq;
    bit exp_rd;
    p = n % FR;
    exp_rd = (n < tm_n0) && act(p) && (widx(p) <= avail(n / FR));
    chk("fifo_rd", 32'(bus.fifo_rd), 32'(exp_rd));
    chk("frame_start", 32'(frame_start), 32'(n % FR == 1));
    chk("underflow", 32'(underflow), 32'(n >= uf_set_n && n < uf_clr_n));
    if (n >= 2) begin
      q  = n - 2;
      qp = q % FR;
      hq = qp % HT;
      vq = qp / HT;
      chk("de", 32'(bus.de), 32'(act(qp)));
      chk("hsync_n", 32'(bus.hsync_n), 32'(!(hq >= 10 && hq < 12)));
      chk("vsync_n", 32'(bus.vsync_n), 32'(vq != 5));
      chk("pixel", 32'(bus.pixel), exp_pix(q));
    end
  endtask

  task automatic step();
    bit rd;
    #1;
    rd = bus.fifo_rd;
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() > 0) bus.fifo_rd_data = fifo_q.pop_front();
    bus.fifo_empty = (fifo_q.size() == 0);
    @(negedge clk);
    n++;
    check_cycle();
  endtask

  task automatic load(input int k);
    for (int i = 1; i <= k; i++) fifo_q.push_back(16'(i));
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_de"}, 32'(bus.de), 32'h0);
    chk({tag, "_hsync_n"}, 32'(bus.hsync_n), 32'h1);
    chk({tag, "_vsync_n"}, 32'(bus.vsync_n), 32'h1);
    chk({tag, "_pixel"}, 32'(bus.pixel), 32'h0);
    chk({tag, "_fifo_rd"}, 32'(bus.fifo_rd), 32'h0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'h0);
    chk({tag, "_underflow"}, 32'(underflow), 32'h0);
  endtask

  initial begin
    bus.fifo_empty   = 1'b1;
    bus.fifo_rd_data = 16'h0;
    #1 rst_n = 1'b0;
    #2 check_reset("rst0");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    check_cycle();

    // Frames 0-1 idle; frame 2 loaded but still waiting; frame 3 runs 32 words
    // with enable dropped mid-frame; frame 5 runs with only 10 words.
    while (n < 689) begin
      step();
      if (n == 196) begin load(32); enable = 1'b1; run_f0 = 3; avail0 = 32; end
      if (n == 314) enable = 1'b0;
      if (n == 400) begin
        load(10); enable = 1'b1; run_f1 = 5; avail1 = 10;
        uf_set_n = 507; uf_clr_n = 601;
      end
      if (n == 518) clr_underflow = 1'b1;
      if (n == 519) clr_underflow = 1'b0;
      if (n == 520) enable = 1'b0;
      if (n == 600) clr_underflow = 1'b1;
      if (n == 601) clr_underflow = 1'b0;
    end

    // Asynchronous reset in the middle of an active line.
    #2 rst_n = 1'b0;
    #1 check_reset("rst_mid");
    @(negedge clk);
    check_reset("rst_hold");
    rst_n = 1'b1;
    n = 0;
    run_f0 = -1; run_f1 = -1;
    uf_set_n = BIG; uf_clr_n = BIG;
    check_cycle();
    while (n < 30) step();

`ifdef VGA_TEST_PATTERN_EN
    test_mode = 1'b1;
    tm_n0 = 30;
    load(1);
    enable = 1'b1;
    while (n < 200) begin
      step();
      if (n == 120) begin
        fifo_q.delete();
        bus.fifo_empty = 1'b1;
      end
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
